// File: rtl/ysyx_23060203_pkg.sv
// Shared types and constants for the ysyx_23060203 fetch-side memory responder.
package ysyx_23060203_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

    localparam logic [31:0] MEM_RESET_WORD = 32'hffff_ffff;
    localparam int unsigned CNT_W          = 4;

    // Deterministic word image so the responder can be built without the C memory model.
    function automatic logic [31:0] mem_read(input logic [31:0] raddr);
        if (raddr == 32'h8000_0000) begin
            return 32'h0000_0413;
        end
        return {raddr[15:0] ^ 16'hC3A5, raddr[31:16] ^ raddr[15:0]};
    endfunction

endpackage

// File: rtl/ysyx_23060203_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps once per enable; only built when
// YSYX_23060203_MEM_RAND_DELAY_EN is defined.
`ifdef YSYX_23060203_MEM_RAND_DELAY_EN
module ysyx_23060203_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule
`endif

// File: rtl/ysyx_23060203_mem_resp.sv
// Single-outstanding word-read responder with fixed or LFSR-randomised response latency.
// YSYX_23060203_MEM_RAND_DELAY_EN switches from LATENCY to a per-request delay of 1..8.
module ysyx_23060203_mem_resp
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned LATENCY   = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    mem_state_t       r_state;
    mem_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_delay_m1;
    logic [31:0]      r_data;
    logic             r_err;
    logic             w_accept;
    logic             w_unused_cfg;

    assign w_accept = req_valid && req_ready;

`ifdef YSYX_23060203_MEM_RAND_DELAY_EN
    logic [7:0] w_lfsr;

    ysyx_23060203_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (w_accept),
        .o_lfsr (w_lfsr)
    );

    // Delay is sampled from the pre-advance LFSR value at acceptance.
    assign w_delay_m1   = {1'b0, w_lfsr[2:0]};
    assign w_unused_cfg = ^{LAT_M1, w_lfsr[7:3]};
`else
    assign w_delay_m1   = LAT_M1;
    assign w_unused_cfg = ^LFSR_SEED;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    w_cnt_nxt   = w_delay_m1;
                    w_state_nxt = (w_delay_m1 == '0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // Gated by rst so a transaction being dropped never shows a response.
                resp_valid = !rst;
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= MEM_RESET_WORD;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_data <= mem_read({req_addr[31:2], 2'b00});
                r_err  <= |req_addr[1:0];
            end
        end
    end

    assign resp_data = r_data;
    assign resp_err  = r_err;

endmodule

// File: doc/ysyx_23060203_mem_resp.md
# ysyx_23060203_mem_resp

Word-wide memory responder serving the fetch side of the core. Accepts one word-read request at a time over a valid/ready request channel and returns the word over a valid/ready response channel after a programmable latency. The word is read through the existing `mem_read` DPI-C function. This block replaces the zero-latency direct fetch, so the IFU can be developed and verified against a memory with realistic, variable delay.

## Interface
Parameters:
- `LATENCY`, default 1: cycles from request acceptance to `resp_valid` rising, in fixed-latency mode; legal range 1..15.
- `LFSR_SEED`, default 8'hA5: reset value of the delay LFSR (random mode only); must be nonzero.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  32  byte address of the requested word.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_data`  out  32  read word.
- `resp_err`  out  1  request was misaligned (`req_addr[1:0] != 0`).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid && req_ready`, capture `mem_read({req_addr[31:2],2'b00})` into the data register and `|req_addr[1:0]` into the error register.
  - Load the down-counter with delay−1.
  - Go to RESP if delay==1, else to WAIT.
- WAIT:
  - `req_ready=0`, `resp_valid=0`.
  - Counter decrements each cycle; when it reaches 1, go to RESP.
- RESP:
  - `resp_valid=1`. `resp_data` and `resp_err` are held stable until the handshake.
  - On `resp_valid && resp_ready`, go to IDLE.
- Misaligned request: still completes with full latency. `resp_data` is the word at the aligned address and `resp_err=1`.
- Counter is 4 bits wide. Delay is never 0.
- One outstanding transaction at a time. No request queueing.

## Timing
- Reset values: `req_ready=0` during the reset cycle, then 1 in IDLE. `resp_valid=0`, `resp_data=32'hffffffff`, `resp_err=0`, counter=0, LFSR=`LFSR_SEED`.
- Request accepted at edge T → `resp_valid` first high in cycle T+delay.
- Throughput: at most one transaction per delay+1 cycles, because `req_ready` is low in RESP.
- Consumer backpressure: RESP is held indefinitely while `resp_ready=0`.
- `rst` asserted in any state:
  - Next state is IDLE and the pending transaction is dropped; no response is ever issued for it.
  - `mem_read` is not called during reset.
- `req_valid` high while `req_ready` is low: ignored. The requester must hold it.
- `resp_ready` high outside RESP: no effect.

## Configuration
- `YSYX_23060203_MEM_RAND_DELAY_EN` defined:
  - Delay per request = `lfsr[2:0]+1` (1..8), sampled at acceptance.
  - 8-bit Fibonacci LFSR, taps 8,6,5,4; advances once per accepted request.
  - `LATENCY` is ignored.
- Macro undefined:
  - Delay = `LATENCY` for every request.
  - No LFSR is instantiated.

## Structure
- `ysyx_23060203_pkg` holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - `MEM_RESET_WORD = 32'hffffffff`;
  - the counter width constant.
- Sub-module `ysyx_23060203_lfsr8` (enable, seed parameter, 8-bit output), instantiated only under the macro.
- The DPI-C import comes from the existing shared DPI include.

## Test plan
- Reset then idle: hold `rst` 2 cycles → `resp_valid=0`, `resp_data=32'hffffffff`; `req_ready=1` in the first cycle after reset.
- Fixed latency: `LATENCY=3`, memory[0x80000000]=0x00000413, request at edge T with `resp_ready=1` → `resp_valid` high only in cycle T+3 with `resp_data=0x00000413`, `resp_err=0`; `req_ready=1` again in cycle T+4.
- Backpressure: same request with `resp_ready=0` for 5 cycles after `resp_valid` rises → data stable and `req_ready=0` throughout; handshake on the 6th cycle → IDLE next cycle.
- Misaligned: `req_addr=0x80000006` → `resp_err=1`, `resp_data`=word at 0x80000004.
- Reset mid-operation: `rst` in the WAIT state → no `resp_valid` afterwards; a new request to 0x80000000 completes normally with latency `LATENCY`.
- Random mode (macro defined): 100 back-to-back requests → every delay lies in 1..8 and matches a reference LFSR model; all data matches memory.
